// File: rtl/hdmi_line_scanout.sv
// Raster timing generator that scans pixels out of a ping-pong pair of line
// buffers, refilled by an upstream master through a level request/ack handshake.
module hdmi_line_scanout #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP = 88,
    parameter int H_SYNC = 44,
    parameter int H_BP = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP = 4,
    parameter int V_SYNC = 5,
    parameter int V_BP = 36,
    parameter int PIX_W = 16,
    parameter int WORD_W = 32,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter logic [PIX_W-1:0] UNDERFLOW_COLOR = {PIX_W{1'b0}},
    localparam int LINE_WORDS = H_ACTIVE / (WORD_W / PIX_W),
    localparam int AW = $clog2(LINE_WORDS)
) (
    input  logic              system_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic              line_req,
    output logic              line_req_bank,
    input  logic              line_ack,
    output logic              hdmi_clk,
    output logic              hdmi_hsync,
    output logic              hdmi_vsync,
    output logic              hdmi_de,
    output logic [PIX_W-1:0]  hdmi_d,
    output logic              frame_start,
    output logic              underflow,
    input  logic              underflow_clr
);
    localparam int PPW = WORD_W / PIX_W;
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int HCW = $clog2(H_TOTAL);
    localparam int VCW = $clog2(V_TOTAL);
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int MAW = $clog2(2 * LINE_WORDS);

    logic [HCW-1:0]    h_cnt_r;
    logic [VCW-1:0]    v_cnt_r;
    logic [1:0]        full_r;
    logic              rd_bank_r;
    logic              line_ok_r;
    logic              line_req_r;
    logic              line_req_bank_r;
    logic              underflow_r;
    logic [WORD_W-1:0] mem_r [0:2*LINE_WORDS-1];
    logic [WORD_W-1:0] rd_word_r;
    logic              s1_hsync_r, s1_vsync_r, s1_de_r, s1_fs_r, s1_ok_r;
    logic [LANE_W-1:0] s1_lane_r;

    int                h_s, v_s, px_s;
    logic              h_act_s, v_act_s, line_start_s, line_last_s;
    logic              ack_ok_s, sample_full_s, rd_bank_next_s;
    logic [1:0]        full_set_s, full_clr_s, full_next_s;
    logic              req_next_s, req_bank_next_s, wr_ok_s;
    logic [MAW-1:0]    rd_addr_s, wr_addr_s;
    logic [LANE_W-1:0] lane_s;

    function automatic logic [PIX_W-1:0] pick_pixel(input logic [WORD_W-1:0] word,
                                                    input logic [LANE_W-1:0] lane);
        logic [PIX_W-1:0] pix;
        pix = word[PIX_W-1:0];
        for (int i = 0; i < PPW; i++) begin
            if (int'(lane) == i) pix = word[i*PIX_W +: PIX_W];
        end
        return pix;
    endfunction

    assign hdmi_clk      = system_clk;
    assign line_req      = line_req_r;
    assign line_req_bank = line_req_bank_r;
    assign underflow     = underflow_r;

    // Raster decode, buffer addressing and next-state of the bank bookkeeping
    always_comb begin
        h_s          = int'(h_cnt_r);
        v_s          = int'(v_cnt_r);
        h_act_s      = (h_s >= H_START) && (h_s < H_START + H_ACTIVE);
        v_act_s      = (v_s >= V_START) && (v_s < V_START + V_ACTIVE);
        px_s         = h_act_s ? (h_s - H_START) : 0;
        rd_addr_s    = rd_bank_r ? MAW'(LINE_WORDS + px_s / PPW) : MAW'(px_s / PPW);
        lane_s       = LANE_W'(px_s % PPW);
        line_start_s = v_act_s && (h_s == H_START - 1);
        line_last_s  = v_act_s && (h_s == H_START + H_ACTIVE - 1) && line_ok_r;
        ack_ok_s     = line_ack && line_req_r;
        // An ack landing on the line-start cycle still rescues the line
        sample_full_s   = full_r[rd_bank_r] || (ack_ok_s && (line_req_bank_r == rd_bank_r));
        full_set_s      = ack_ok_s ? (2'b01 << line_req_bank_r) : 2'b00;
        full_clr_s      = line_last_s ? (2'b01 << rd_bank_r) : 2'b00;
        full_next_s     = (full_r | full_set_s) & ~full_clr_s;
        rd_bank_next_s  = rd_bank_r ^ line_last_s;
        req_next_s      = ~&full_next_s;
        req_bank_next_s = full_next_s[rd_bank_next_s] ? ~rd_bank_next_s : rd_bank_next_s;
        wr_ok_s         = wr_en && (int'(wr_addr) < LINE_WORDS);
        wr_addr_s       = wr_bank ? MAW'(LINE_WORDS + int'(wr_addr)) : MAW'(wr_addr);
    end

    // Horizontal / vertical raster counters
    always_ff @(posedge system_clk) begin
        if (reset) begin
            h_cnt_r <= {HCW{1'b0}};
            v_cnt_r <= {VCW{1'b0}};
        end else if (h_cnt_r == HCW'(H_TOTAL - 1)) begin
            h_cnt_r <= {HCW{1'b0}};
            v_cnt_r <= (v_cnt_r == VCW'(V_TOTAL - 1)) ? {VCW{1'b0}} : v_cnt_r + VCW'(1);
        end else begin
            h_cnt_r <= h_cnt_r + HCW'(1);
        end
    end

    // Bank full flags, display bank, refill request and sticky underflow
    always_ff @(posedge system_clk) begin
        if (reset) begin
            full_r          <= 2'b00;
            rd_bank_r       <= 1'b0;
            line_ok_r       <= 1'b0;
            line_req_r      <= 1'b0;
            line_req_bank_r <= 1'b0;
            underflow_r     <= 1'b0;
        end else begin
            full_r          <= full_next_s;
            rd_bank_r       <= rd_bank_next_s;
            line_req_r      <= req_next_s;
            line_req_bank_r <= req_bank_next_s;
            if (line_start_s) line_ok_r <= sample_full_s;
            if (line_start_s && !sample_full_s) underflow_r <= 1'b1;
            else if (underflow_clr) underflow_r <= 1'b0;
        end
    end

    // Line buffer: one write port, one registered read port
    always_ff @(posedge system_clk) begin
        if (wr_ok_s) mem_r[wr_addr_s] <= wr_data;
        rd_word_r <= mem_r[rd_addr_s];
    end

    // Stage 1: timing bits travel alongside the memory read
    always_ff @(posedge system_clk) begin
        if (reset) begin
            s1_hsync_r <= ~HSYNC_POL;
            s1_vsync_r <= ~VSYNC_POL;
            s1_de_r    <= 1'b0;
            s1_fs_r    <= 1'b0;
            s1_ok_r    <= 1'b0;
            s1_lane_r  <= {LANE_W{1'b0}};
        end else begin
            s1_hsync_r <= (h_s < H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            s1_vsync_r <= (v_s < V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            s1_de_r    <= h_act_s && v_act_s;
            s1_fs_r    <= (h_s == 0) && (v_s == 0);
            s1_ok_r    <= line_ok_r;
            s1_lane_r  <= lane_s;
        end
    end

    // Stage 2: output registers with lane select
    always_ff @(posedge system_clk) begin
        if (reset) begin
            hdmi_hsync  <= ~HSYNC_POL;
            hdmi_vsync  <= ~VSYNC_POL;
            hdmi_de     <= 1'b0;
            hdmi_d      <= {PIX_W{1'b0}};
            frame_start <= 1'b0;
        end else begin
            hdmi_hsync  <= s1_hsync_r;
            hdmi_vsync  <= s1_vsync_r;
            hdmi_de     <= s1_de_r;
            frame_start <= s1_fs_r;
            hdmi_d      <= !s1_de_r ? {PIX_W{1'b0}} :
                           (s1_ok_r ? pick_pixel(rd_word_r, s1_lane_r) : UNDERFLOW_COLOR);
        end
    end
endmodule

// File: tb/tb_hdmi_line_scanout.sv
// Bench for hdmi_line_scanout: small raster, randomized refills, checked against
// a line-FIFO reference model of the ping-pong buffers.
module tb_hdmi_line_scanout;
    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int PIX_W = 8, WORD_W = 32;
    localparam int PPW = WORD_W / PIX_W;
    localparam int LINE_WORDS = H_ACTIVE / PPW;
    localparam int AW = $clog2(LINE_WORDS);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int FRAME = H_TOTAL * V_TOTAL;
    localparam int HS = H_SYNC + H_BP;
    localparam int VS = V_SYNC + V_BP;
    localparam logic [PIX_W-1:0] UF_COLOR = 8'hE7;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic [PIX_W-1:0] d;
    } out_t;
    typedef logic [H_ACTIVE*PIX_W-1:0] line_t;

    logic system_clk = 1'b0;
    logic reset = 1'b1;
    logic wr_en = 1'b0, wr_bank = 1'b0, line_ack = 1'b0, underflow_clr = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [WORD_W-1:0] wr_data = '0;
    logic line_req, line_req_bank, hdmi_clk, hdmi_hsync, hdmi_vsync, hdmi_de, frame_start, underflow;
    logic [PIX_W-1:0] hdmi_d;
    logic n_line_req, n_line_req_bank, n_hdmi_clk, n_hsync, n_vsync, n_de, n_frame_start, n_underflow;
    logic [PIX_W-1:0] n_d;

    int checks = 0;
    int errors = 0;

    // model state
    out_t  out_q[$];
    line_t line_q[$];
    line_t cur, fill_line, directed_line;
    int    k, pushes, fill_w, fill_limit, fill_pct, fill_at;
    bit    disp, uf_exp, req_exp, bank_exp, fill_active, fill_bank;
    bit    use_directed, rand_clr, clr_pending;

    always #5 system_clk = ~system_clk;

    hdmi_line_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PIX_W(PIX_W), .WORD_W(WORD_W), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .UNDERFLOW_COLOR(UF_COLOR)
    ) u_dut (
        .system_clk(system_clk), .reset(reset), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .line_req(line_req),
        .line_req_bank(line_req_bank), .line_ack(line_ack), .hdmi_clk(hdmi_clk),
        .hdmi_hsync(hdmi_hsync), .hdmi_vsync(hdmi_vsync), .hdmi_de(hdmi_de),
        .hdmi_d(hdmi_d), .frame_start(frame_start), .underflow(underflow),
        .underflow_clr(underflow_clr)
    );

    hdmi_line_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PIX_W(PIX_W), .WORD_W(WORD_W), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .UNDERFLOW_COLOR(UF_COLOR)
    ) u_dut_neg (
        .system_clk(system_clk), .reset(reset), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .line_req(n_line_req),
        .line_req_bank(n_line_req_bank), .line_ack(line_ack), .hdmi_clk(n_hdmi_clk),
        .hdmi_hsync(n_hsync), .hdmi_vsync(n_vsync), .hdmi_de(n_de),
        .hdmi_d(n_d), .frame_start(n_frame_start), .underflow(n_underflow),
        .underflow_clr(underflow_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at k=%0d: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
        end
    endtask

    task automatic do_reset();
        out_t idle;
        idle = '0;
        reset = 1'b1; wr_en = 1'b0; line_ack = 1'b0; underflow_clr = 1'b0;
        wr_bank = 1'b0; wr_addr = '0; wr_data = '0; fill_active = 1'b0;
        @(posedge system_clk); #1;
        @(negedge system_clk);
        chk("rst_hsync", hdmi_hsync, 64'd0);
        chk("rst_vsync", hdmi_vsync, 64'd0);
        chk("rst_de", hdmi_de, 64'd0);
        chk("rst_d", hdmi_d, 64'd0);
        chk("rst_frame_start", frame_start, 64'd0);
        chk("rst_line_req", line_req, 64'd0);
        chk("rst_line_req_bank", line_req_bank, 64'd0);
        chk("rst_underflow", underflow, 64'd0);
        chk("rst_hsync_neg", n_hsync, 64'd1);
        chk("rst_vsync_neg", n_vsync, 64'd1);
        @(posedge system_clk); #1;
        reset = 1'b0;
        k = 0; pushes = 0; disp = 1'b0; uf_exp = 1'b0; req_exp = 1'b0; bank_exp = 1'b0;
        line_q.delete();
        out_q.delete();
        out_q.push_back(idle);
        out_q.push_back(idle);
    endtask

    task automatic one_cycle();
        bit start, ack_now, clr_now, hact, vact, uf_set;
        int h, v;
        out_t e, nxt;
        wr_en = 1'b0; line_ack = 1'b0; ack_now = 1'b0;
        underflow_clr = clr_pending || (rand_clr && ($urandom_range(0, 59) == 0));
        clr_now = underflow_clr;
        clr_pending = 1'b0;
        start = !fill_active && req_exp && (pushes < fill_limit) &&
                ((fill_at >= 0) ? (k == fill_at) : ($urandom_range(0, 99) < fill_pct));
        if (start) begin
            fill_active = 1'b1; fill_w = 0; fill_bank = bank_exp;
            fill_line = use_directed ? directed_line : {$urandom, $urandom};
        end
        if (fill_active) begin
            if (fill_w < LINE_WORDS) begin
                wr_en = 1'b1; wr_bank = fill_bank; wr_addr = AW'(fill_w);
                wr_data = fill_line[fill_w*WORD_W +: WORD_W];
                fill_w++;
            end else begin
                line_ack = 1'b1; ack_now = 1'b1; fill_active = 1'b0;
            end
        end

        @(negedge system_clk);
        e = out_q.pop_front();
        chk("hsync", hdmi_hsync, e.hs);
        chk("vsync", hdmi_vsync, e.vs);
        chk("de", hdmi_de, e.de);
        chk("frame_start", frame_start, e.fs);
        if (e.de) chk("pixel", hdmi_d, e.d);
        chk("line_req", line_req, req_exp);
        if (req_exp) chk("line_req_bank", line_req_bank, bank_exp);
        chk("underflow", underflow, uf_exp);
        chk("hdmi_clk", hdmi_clk, 64'd0);
        chk("hsync_neg", n_hsync, !e.hs);
        chk("vsync_neg", n_vsync, !e.vs);
        chk("de_neg", n_de, e.de);
        chk("frame_start_neg", n_frame_start, e.fs);
        if (e.de) chk("pixel_neg", n_d, e.d);
        chk("line_req_neg", n_line_req, req_exp);
        if (req_exp) chk("line_req_bank_neg", n_line_req_bank, bank_exp);
        chk("underflow_neg", n_underflow, uf_exp);
        chk("hdmi_clk_neg", n_hdmi_clk, 64'd0);

        // reference model: counter state of cycle k and the line FIFO
        h = k % H_TOTAL;
        v = (k / H_TOTAL) % V_TOTAL;
        hact = (h >= HS) && (h < HS + H_ACTIVE);
        vact = (v >= VS) && (v < VS + V_ACTIVE);
        nxt.hs = (h < H_SYNC);
        nxt.vs = (v < V_SYNC);
        nxt.de = hact && vact;
        nxt.fs = (h == 0) && (v == 0);
        nxt.d = 8'h00;
        if (nxt.de) nxt.d = disp ? cur[(h - HS)*PIX_W +: PIX_W] : UF_COLOR;
        out_q.push_back(nxt);
        if (ack_now) begin
            line_q.push_back(fill_line);
            pushes++;
        end
        uf_set = 1'b0;
        if (vact && (h == HS - 1)) begin
            if (line_q.size() > 0) begin
                disp = 1'b1; cur = line_q[0];
            end else begin
                disp = 1'b0; uf_set = 1'b1;
            end
        end
        if (vact && (h == HS + H_ACTIVE - 1) && disp) void'(line_q.pop_front());
        if (uf_set) uf_exp = 1'b1;
        else if (clr_now) uf_exp = 1'b0;
        req_exp = (line_q.size() < 2);
        bank_exp = ((pushes % 2) == 1);
        k++;
        @(posedge system_clk); #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) one_cycle();
    endtask

    initial begin
        fill_limit = 0; fill_pct = 0; fill_at = -1;
        use_directed = 1'b0; rand_clr = 1'b0; clr_pending = 1'b0;
        directed_line = 64'h0807060504030201;

        // no refills: pure timing, underflow colour on every active line
        do_reset();
        run(2 * FRAME);
        clr_pending = 1'b1;
        run(FRAME);

        // one directed line into bank 0
        do_reset();
        use_directed = 1'b1; fill_limit = 1; fill_pct = 100;
        run(FRAME);
        use_directed = 1'b0;

        // both banks filled then starved: two lines shown, third underflows
        do_reset();
        fill_limit = 2; fill_pct = 100;
        run(FRAME);
        clr_pending = 1'b1;
        run(20);

        // ack lands exactly on the first line-start cycle (h=HS-1, v=VS)
        do_reset();
        fill_limit = 1; fill_at = VS * H_TOTAL + HS - 1 - LINE_WORDS;
        run(FRAME);
        fill_at = -1;

        // randomized refills and clears
        do_reset();
        fill_limit = 1000000; fill_pct = 30; rand_clr = 1'b1;
        run(3 * FRAME);

        // reset in the middle of an active line, then no refills
        for (int i = 0; (i < 2 * FRAME) && !out_q[0].de; i++) one_cycle();
        fill_limit = 0; fill_pct = 0; rand_clr = 1'b0;
        do_reset();
        run(FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
